hazard_controller: RTL and testbench

- Pipeline hazard sequencer for the 5-stage MIPS core. Sits in ID/EX beside the forwarding unit.
- Covers the hazards forwarding cannot resolve:
  - load-use hazard: one-cycle stall plus bubble;
  - taken branch resolved in EX: flush of IF/ID and ID/EX;
  - multi-cycle mul/div in EX: freeze IF/ID/EX for MD_CYCLES cycles, bubbles into MEM.
- Drives pipeline-register write enables and flush/bubble controls.

---
 rtl/hazard_controller.sv | 201 ++++++++++++++++++++
 tb/tb_hazard_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
//
// Pipeline hazard sequencer for the 5-stage MIPS core, placed in ID/EX beside
// the forwarding unit. It handles the hazards forwarding cannot resolve:
//   - load-use:       one stall cycle, with a bubble injected into ID/EX
//   - taken branch:   flush IF/ID and bubble ID/EX (branch resolved in EX)
//   - mul/div in EX:  freeze IF/ID/EX for MD_CYCLES cycles, bubbles into MEM
//
// All control outputs are combinational from the FSM state and the inputs,
// so every response takes effect in the same cycle as its cause.
//
// Parameters:
//   MD_CYCLES  total frozen cycles for a mul/div op (1..255)
//   CNT_W      width of the mul/div countdown (must hold MD_CYCLES-1)
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   Rs_ID, Rt_ID               source register fields of the ID instruction
//   RsUsed_ID, RtUsed_ID       ID instruction actually reads Rs / Rt
//   Rt_EX                      destination of the EX instruction
//   MemRead_EX                 EX instruction is a load
//   BranchTaken_EX             branch in EX resolved taken
//   MdStart_EX                 EX instruction is mul/div (held while in EX)
//   PCWrite, IFIDWrite,
//   IDEXWrite                  pipeline register write enables
//   IFIDFlush                  zero IF/ID contents
//   IDEXBubble, EXMEMBubble    zero ID/EX, EX/MEM control signals
//   MdBusy                     high while in MD_WAIT
//   MdDone                     one-cycle pulse on the last frozen cycle
//
// Optional build macro HAZ_PERF_CNT_EN adds saturating 16-bit counters
//   LuStallCnt, FlushCnt, MdStallCnt counting load-use stall, branch flush
//   and mul/div freeze cycles. Without the macro they do not exist.
// -----------------------------------------------------------------------------
module hazard_controller #(
    parameter int MD_CYCLES = 8,
    parameter int CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  Rs_ID,
    input  logic [4:0]  Rt_ID,
    input  logic        RsUsed_ID,
    input  logic        RtUsed_ID,
    input  logic [4:0]  Rt_EX,
    input  logic        MemRead_EX,
    input  logic        BranchTaken_EX,
    input  logic        MdStart_EX,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IDEXWrite,
    output logic        IFIDFlush,
    output logic        IDEXBubble,
    output logic        EXMEMBubble,
    output logic        MdBusy,
    output logic        MdDone
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [15:0] LuStallCnt,
    output logic [15:0] FlushCnt,
    output logic [15:0] MdStallCnt
`endif
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    // The start cycle is the first frozen cycle, so MD_WAIT covers the rest.
    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic             MD_ONE  = (MD_CYCLES == 1);

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             lu;

    // Load-use: $0 is hard-wired zero, so it can never carry a hazard.
    assign lu = MemRead_EX && (Rt_EX != 5'd0) &&
                ((RsUsed_ID && (Rs_ID == Rt_EX)) ||
                 (RtUsed_ID && (Rt_ID == Rt_EX)));

    // State register and countdown.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic.
    // NOTE: every variable gets a default first, so no path through the
    // case leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        case (state)
            RUN: begin
                // A taken branch squashes the mul/div in EX, so it wins.
                if (!BranchTaken_EX && MdStart_EX) begin
                    cnt_next = MD_LOAD;
                    if (!MD_ONE) begin
                        next_state = MD_WAIT;
                    end
                end
            end
            MD_WAIT: begin
                if (cnt != '0) begin
                    cnt_next = cnt - CNT_ONE;
                end
                // Exit on the last count; a zero count can only come from a
                // corrupted state and is treated the same way.
                if (cnt <= CNT_ONE) begin
                    next_state = RUN;
                end
            end
            default: begin
                next_state = RUN;
                cnt_next   = '0;
            end
        endcase
    end

    // Output logic.
    always_comb begin
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IDEXWrite   = 1'b1;
        IFIDFlush   = 1'b0;
        IDEXBubble  = 1'b0;
        EXMEMBubble = 1'b0;
        MdBusy      = 1'b0;
        MdDone      = 1'b0;
        case (state)
            RUN: begin
                if (BranchTaken_EX) begin
                    IFIDFlush  = 1'b1;
                    IDEXBubble = 1'b1;
                end else if (MdStart_EX) begin
                    PCWrite     = 1'b0;
                    IFIDWrite   = 1'b0;
                    IDEXWrite   = 1'b0;
                    EXMEMBubble = 1'b1;
                    MdDone      = MD_ONE;
                end else if (lu) begin
                    // Single stall: the bubble clears MemRead_EX next cycle.
                    PCWrite    = 1'b0;
                    IFIDWrite  = 1'b0;
                    IDEXBubble = 1'b1;
                end
            end
            MD_WAIT: begin
                PCWrite     = 1'b0;
                IFIDWrite   = 1'b0;
                IDEXWrite   = 1'b0;
                EXMEMBubble = 1'b1;
                MdBusy      = 1'b1;
                MdDone      = (cnt <= CNT_ONE);
            end
            default: begin
            end
        endcase
    end

`ifdef HAZ_PERF_CNT_EN
    // Activity is decoded from the outputs: a flush is the only case that
    // raises IFIDFlush, EXMEMBubble is raised only by a mul/div freeze, and
    // IDEXBubble without a flush is a load-use stall.
    logic lu_stall_act, flush_act, md_freeze_act;

    assign flush_act     = IFIDFlush;
    assign md_freeze_act = EXMEMBubble;
    assign lu_stall_act  = IDEXBubble && !IFIDFlush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            LuStallCnt <= '0;
            FlushCnt   <= '0;
            MdStallCnt <= '0;
        end else begin
            if (lu_stall_act && (LuStallCnt != 16'hFFFF)) begin
                LuStallCnt <= LuStallCnt + 16'd1;
            end
            if (flush_act && (FlushCnt != 16'hFFFF)) begin
                FlushCnt <= FlushCnt + 16'd1;
            end
            if (md_freeze_act && (MdStallCnt != 16'hFFFF)) begin
                MdStallCnt <= MdStallCnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// -----------------------------------------------------------------------------
// tb_hazard_controller
//
// Drives two hazard_controller instances from the same inputs: one with
// MD_CYCLES=8 and one with MD_CYCLES=1. A cycle-level model tracks each
// instance's mul/div op as "frozen cycles already spent" and derives the
// expected outputs from the hazard priority rules. The compare process checks
// both instances on every falling edge; directed steps add literal checks.
// Output vectors are packed as
//   {PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXBubble, EXMEMBubble,
//    MdBusy, MdDone}.
// -----------------------------------------------------------------------------
module tb_hazard_controller;

    logic       clk;
    logic       rst_n;
    logic [4:0] Rs_ID, Rt_ID, Rt_EX;
    logic       RsUsed_ID, RtUsed_ID, MemRead_EX, BranchTaken_EX, MdStart_EX;

    logic pcw8, ifw8, idw8, fl8, idb8, exb8, busy8, done8;
    logic pcw1, ifw1, idw1, fl1, idb1, exb1, busy1, done1;
    logic [7:0] out8, out1;

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] lu_cnt8, fl_cnt8, md_cnt8;
    logic [15:0] lu_cnt1, fl_cnt1, md_cnt1;
`endif

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  chk_en = 0;
    int  ph8 = 0;
    int  ph1 = 0;
    int  m_lu = 0, m_fl = 0, m_md = 0;

    localparam logic [7:0] O_IDLE  = 8'hE0;
    localparam logic [7:0] O_LU    = 8'h28;
    localparam logic [7:0] O_BR    = 8'hF8;
    localparam logic [7:0] O_MDST  = 8'h04;
    localparam logic [7:0] O_MDW   = 8'h06;
    localparam logic [7:0] O_MDEND = 8'h07;
    localparam logic [7:0] O_MD1   = 8'h05;

    hazard_controller #(.MD_CYCLES(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .RsUsed_ID(RsUsed_ID), .RtUsed_ID(RtUsed_ID),
        .Rt_EX(Rt_EX), .MemRead_EX(MemRead_EX), .BranchTaken_EX(BranchTaken_EX),
        .MdStart_EX(MdStart_EX),
        .PCWrite(pcw8), .IFIDWrite(ifw8), .IDEXWrite(idw8), .IFIDFlush(fl8),
        .IDEXBubble(idb8), .EXMEMBubble(exb8), .MdBusy(busy8), .MdDone(done8)
`ifdef HAZ_PERF_CNT_EN
        , .LuStallCnt(lu_cnt8), .FlushCnt(fl_cnt8), .MdStallCnt(md_cnt8)
`endif
    );

    hazard_controller #(.MD_CYCLES(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .RsUsed_ID(RsUsed_ID), .RtUsed_ID(RtUsed_ID),
        .Rt_EX(Rt_EX), .MemRead_EX(MemRead_EX), .BranchTaken_EX(BranchTaken_EX),
        .MdStart_EX(MdStart_EX),
        .PCWrite(pcw1), .IFIDWrite(ifw1), .IDEXWrite(idw1), .IFIDFlush(fl1),
        .IDEXBubble(idb1), .EXMEMBubble(exb1), .MdBusy(busy1), .MdDone(done1)
`ifdef HAZ_PERF_CNT_EN
        , .LuStallCnt(lu_cnt1), .FlushCnt(fl_cnt1), .MdStallCnt(md_cnt1)
`endif
    );

    assign out8 = {pcw8, ifw8, idw8, fl8, idb8, exb8, busy8, done8};
    assign out1 = {pcw1, ifw1, idw1, fl1, idb1, exb1, busy1, done1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs given how many frozen cycles the current mul/div op
    // has already spent (0 = no op in progress).
    function automatic logic [7:0] model_out(input int md_cycles, input int phase,
                                             input logic br, input logic md, input logic lu);
        if (phase > 0)
            return {6'b000001, 1'b1, 1'(phase + 1 == md_cycles)};
        else if (br)
            return O_BR;
        else if (md)
            return {6'b000001, 1'b0, 1'(md_cycles == 1)};
        else if (lu)
            return O_LU;
        else
            return O_IDLE;
    endfunction

    function automatic int model_next(input int md_cycles, input int phase,
                                      input logic br, input logic md);
        if (phase > 0)
            return (phase + 1 == md_cycles) ? 0 : phase + 1;
        else if (!br && md)
            return (md_cycles == 1) ? 0 : 1;
        else
            return 0;
    endfunction

    // Compare process: inputs are stable at the falling edge.
    always @(negedge clk) begin
        logic       lu_m;
        logic [7:0] exp8, exp1;
        if (!rst_n) begin
            ph8 = 0; ph1 = 0;
            m_lu = 0; m_fl = 0; m_md = 0;
        end
        lu_m = MemRead_EX && (Rt_EX != 5'd0) &&
               ((RsUsed_ID && Rs_ID == Rt_EX) || (RtUsed_ID && Rt_ID == Rt_EX));
        exp8 = model_out(8, ph8, BranchTaken_EX, MdStart_EX, lu_m);
        exp1 = model_out(1, ph1, BranchTaken_EX, MdStart_EX, lu_m);
        if (chk_en) begin
            check("model_md8", {8'h00, out8}, {8'h00, exp8});
            check("model_md1", {8'h00, out1}, {8'h00, exp1});
`ifdef HAZ_PERF_CNT_EN
            check("perf_lu", lu_cnt8, 16'(m_lu));
            check("perf_flush", fl_cnt8, 16'(m_fl));
            check("perf_md", md_cnt8, 16'(m_md));
`endif
        end
        if (rst_n) begin
            if (ph8 > 0 || (!BranchTaken_EX && MdStart_EX)) m_md++;
            else if (BranchTaken_EX) m_fl++;
            else if (lu_m) m_lu++;
            ph8 = model_next(8, ph8, BranchTaken_EX, MdStart_EX);
            ph1 = model_next(1, ph1, BranchTaken_EX, MdStart_EX);
        end
    end

    task automatic apply(input logic [4:0] rs, input logic [4:0] rt, input logic rsu,
                         input logic rtu, input logic [4:0] rtex, input logic mr,
                         input logic br, input logic md);
        @(posedge clk);
        #1;
        Rs_ID = rs; Rt_ID = rt; RsUsed_ID = rsu; RtUsed_ID = rtu;
        Rt_EX = rtex; MemRead_EX = mr; BranchTaken_EX = br; MdStart_EX = md;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        Rs_ID = '0; Rt_ID = '0; RsUsed_ID = 0; RtUsed_ID = 0;
        Rt_EX = '0; MemRead_EX = 0; BranchTaken_EX = 0; MdStart_EX = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_defaults", {8'h00, out8}, {8'h00, O_IDLE});
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1;

        apply(0, 0, 0, 0, 0, 0, 0, 0);
        check("idle", {8'h00, out8}, {8'h00, O_IDLE});
        apply(5, 0, 1, 0, 5, 1, 0, 0);
        check("lu_rs_md8", {8'h00, out8}, {8'h00, O_LU});
        check("lu_rs_md1", {8'h00, out1}, {8'h00, O_LU});
        // The injected bubble removes the load from EX on the next cycle.
        apply(5, 0, 1, 0, 5, 0, 0, 0);
        check("lu_one_cycle", {8'h00, out8}, {8'h00, O_IDLE});
        apply(0, 0, 1, 0, 0, 1, 0, 0);
        check("lu_reg0", {8'h00, out8}, {8'h00, O_IDLE});
        apply(5, 0, 0, 0, 5, 1, 0, 0);
        check("lu_unused", {8'h00, out8}, {8'h00, O_IDLE});
        apply(0, 7, 0, 1, 7, 1, 0, 0);
        check("lu_rt", {8'h00, out8}, {8'h00, O_LU});
        apply(5, 0, 1, 0, 5, 1, 1, 0);
        check("br_over_lu", {8'h00, out8}, {8'h00, O_BR});
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        check("idle2", {8'h00, out8}, {8'h00, O_IDLE});

        // Mul/div held in EX for 8 cycles; branch on cycle 3 and LU on
        // cycle 5 must not disturb the frozen pipeline.
        for (int i = 1; i <= 8; i++) begin
            apply((i == 5) ? 5'd5 : 5'd0, 0, (i == 5), 0, (i == 5) ? 5'd5 : 5'd0,
                  (i == 5), (i == 3), 1);
            if (i == 1) begin
                check("md_start", {8'h00, out8}, {8'h00, O_MDST});
                check("md1_single", {8'h00, out1}, {8'h00, O_MD1});
            end else if (i == 8) begin
                check("md_done", {8'h00, out8}, {8'h00, O_MDEND});
            end else begin
                check("md_wait", {8'h00, out8}, {8'h00, O_MDW});
            end
        end
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        check("md_after", {8'h00, out8}, {8'h00, O_IDLE});

        // Reset during the fourth frozen cycle.
        for (int i = 1; i <= 4; i++) begin
            apply(0, 0, 0, 0, 0, 0, 0, 1);
        end
        check("md_pre_rst", {8'h00, out8}, {8'h00, O_MDW});
        rst_n = 1'b0;
        MdStart_EX = 0;
        #1;
        check("rst_mid_freeze", {8'h00, out8}, {8'h00, O_IDLE});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        check("post_rst_idle", {8'h00, out8}, {8'h00, O_IDLE});
        apply(5, 0, 1, 0, 5, 1, 0, 0);
        check("post_rst_lu", {8'h00, out8}, {8'h00, O_LU});
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
